bf16_dot_cim_seq: RTL and testbench
===================================

// Module: bf16_dot_cim_seq
// PURPOSE
//  N-lane BF16 dot product for the floating-point CIM macro: sum_i(A_i*B_i) -> one BF16 result.
//  Exponents are aligned on products (not operands), so nothing is lost before multiplication.
//  Products are accumulated serially, one lane per cycle, in a two's-complement accumulator.
//  Valid/ready handshakes on both sides; sits between the CIM input buffer and the BF16 output collector.
// PARAMETERS
//  N      4  lanes per dot product (>=1)
//  GUARD  3  extra alignment LSBs kept below the 14-bit product fraction
//  (derived) PW = 16+GUARD ; ACC_W = PW+1+$clog2(N) ; FRAC = 14+GUARD
// PORTS
//  clk        in   1     clock, single clock domain
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operand vectors valid
//  in_ready   out  1     block can accept operands
//  bf16_a     in   16*N  lane i at [16*(N-i)-1 -: 16] (lane 0 = MSBs)
//  bf16_b     in   16*N  same packing as bf16_a
//  out_valid  out  1     dot_out valid
//  out_ready  in   1     consumer takes dot_out
//  dot_out    out  16    BF16 result {sign,exp[7:0],mant[6:0]}
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, dot_out=16'h0000, acc=0, lane cnt=0.
//  FSM: IDLE -> MAXEXP -> ACC (N cycles) -> NORM -> OUT -> IDLE.
//   IDLE: in_ready=1. When in_valid&in_ready, capture both vectors and go to MAXEXP.
//   MAXEXP: per lane pe=eA+eB (9b). Record max pe over non-zero lanes.
//           Set special=1 if any operand has exp==8'hFF.
//   ACC: lane cnt 0..N-1 advances one lane per cycle.
//        mag = ({1,mA}*{1,mB}) << GUARD, then >> (maxpe-pe). Shift >= PW gives 0.
//        acc += (sA^sB) ? -mag : mag. Leave ACC when cnt==N-1.
//   NORM: one cycle. Take |acc|, sign = acc MSB, p = leading-one index.
//         e = maxpe - 127 + p - FRAC. mant = 7 bits below p, truncated (zero-fill if p<7).
//         Register dot_out with this priority:
//           special -> 16'h7FC0
//           acc==0 or no non-zero lane -> 16'h0000
//           e<=0 -> {sign,15'h0}
//           e>=255 -> {sign,8'hFF,7'h0}
//           else {sign,e[7:0],mant}
//   OUT: out_valid=1 and dot_out is held stable. Return to IDLE when out_ready=1.
//  Operand exp==0 (zero/denormal) is flushed: product is 0 and excluded from the maxpe search.
//  Latency: out_valid rises N+2 edges after the accepting edge. Throughput: one op per N+4 cycles min.
//  in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored, with no side effects.
//  out_valid stays 1 indefinitely under back-pressure (out_ready=0).
//  No new accept in the same cycle as the OUT handshake; the next accept is possible the cycle after.
//  acc and lane cnt are cleared on every accept. No state carries over between operations.
//  Reset mid-operation aborts the operation; no partial result is ever presented.
// STRUCTURE
//  Shared package bf16_cim_pkg:
//   - constants BF16_BIAS=127, BF16_QNAN=16'h7FC0, EXP_W=8, MANT_W=7
//   - FSM state encoding
//   - function bf16_unpack -> {sign,exp,mant_with_hidden}
//  Sub-module bf16_lzd #(W): combinational leading-one detector on ACC_W bits; returns index and zero flag.
//  Everything else (FSM, lane mux, MAC, packer) lives in this file.
// TESTING
//  1 N=2, A={3F80,4000}, B={3F80,3F80} -> dot_out=4040 (3.0); out_valid rises N+2 edges after the accept.
//  2 Cancellation: A={3F80,BF80}, B={3F80,3F80} -> 0000. Also all-zero operands -> 0000.
//  3 Alignment loss: A={4300,3F80}, B={3F80,3B80} -> 4300 (128 + 2^-8 truncated).
//    Also A={C000,3F80}, B={3F80,3F80} -> BF80.
//  4 Specials: A0=7F80, other lanes finite -> 7FC0.
//    Overflow A={7F00,7F00}, B={4000,4000} -> 7F80. Underflow A={0080,..}, B={0080,..} -> 0000.
//  5 Back-pressure: hold out_ready=0 for 5 cycles -> dot_out stable, out_valid=1, in_ready=0.
//    in_valid pulsed meanwhile is not captured. After the release cycle, in_ready returns to 1.
//  6 Assert rst_n low mid-ACC -> out_valid=0, dot_out=0000 immediately, in_ready=1 after release.
//    Next op (test 1 vectors) -> 4040.

Source files
------------

// File: rtl/bf16_cim_pkg.sv
// Shared definitions for the BF16 CIM dot-product path: format constants,
// sequencer state encoding and the operand unpack helper.
package bf16_cim_pkg;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam int          EXP_W     = 8;
    localparam int          MANT_W    = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAXEXP = 3'd1,
        ST_ACC    = 3'd2,
        ST_NORM   = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W:0]   mant;   // hidden bit included
    } bf16_unp_t;

    function automatic bf16_unp_t bf16_unpack(input logic [15:0] v);
        bf16_unp_t r;
        r.sign = v[15];
        r.exp  = v[14:7];
        r.mant = {(v[14:7] != 8'h00), v[6:0]};
        return r;
    endfunction

endpackage

// File: rtl/bf16_lzd.sv
// Combinational leading-one detector: index of the highest set bit and an
// all-zero flag.
module bf16_lzd #(
    parameter int W = 8
) (
    input  logic [W-1:0]                     i_data,
    output logic [((W>1)?$clog2(W):1)-1:0]   o_idx,
    output logic                             o_zero
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [IW-1:0] w_idx;

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < W; i++) begin
            w_idx = i_data[i] ? IW'(i) : w_idx;
        end
    end

    assign o_idx  = w_idx;
    assign o_zero = (i_data == '0);

endmodule

// File: rtl/bf16_dot_cim_seq.sv
// Serial N-lane BF16 dot product: products aligned to the largest product
// exponent, accumulated one lane per cycle, then normalised to one BF16.
module bf16_dot_cim_seq
    import bf16_cim_pkg::*;
#(
    parameter int N     = 4,
    parameter int GUARD = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] bf16_a,
    input  logic [16*N-1:0] bf16_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     dot_out
);

    localparam int PW    = 16 + GUARD;
    localparam int ACC_W = PW + 1 + $clog2(N);
    localparam int FRAC  = 14 + GUARD;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int IW    = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [16*N-1:0]    r_a;
    logic [16*N-1:0]    r_b;
    logic [8:0]         r_maxpe;
    logic               r_nz;
    logic               r_special;
    logic [ACC_W-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [15:0]        r_dot_out;

    logic               w_accept;
    logic [8:0]         w_maxpe;
    logic               w_nz;
    logic               w_special;
    logic [EXP_W-1:0]   w_ea;
    logic [EXP_W-1:0]   w_eb;
    logic [8:0]         w_pe_i;
    logic               w_lane_nz;

    bf16_unp_t          w_ua;
    bf16_unp_t          w_ub;
    logic [8:0]         w_pe;
    logic [8:0]         w_shift;
    logic [15:0]        w_prod;
    logic [PW-1:0]      w_prod_g;
    logic [PW-1:0]      w_mag;
    logic [ACC_W-1:0]   w_mag_ext;
    logic [ACC_W-1:0]   w_term;

    logic [ACC_W-1:0]   w_abs;
    logic [IW-1:0]      w_p;
    logic               w_zero;
    logic signed [11:0] w_e;
    logic [MANT_W-1:0]  w_mant;
    logic               w_sign;
    logic [15:0]        w_result;

    assign w_accept  = in_valid & r_in_ready & (r_state == ST_IDLE);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dot_out   = r_dot_out;

    // Sequencer next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_MAXEXP;
                else          w_state_nxt = ST_IDLE;
            end
            ST_MAXEXP: w_state_nxt = ST_ACC;
            ST_ACC: begin
                if (r_cnt == CW'(N-1)) w_state_nxt = ST_NORM;
                else                   w_state_nxt = ST_ACC;
            end
            ST_NORM: w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (out_ready) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_OUT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Largest product exponent over lanes with both operands non-zero.
    always_comb begin
        w_maxpe   = 9'd0;
        w_nz      = 1'b0;
        w_special = 1'b0;
        w_ea      = 8'h00;
        w_eb      = 8'h00;
        w_pe_i    = 9'd0;
        w_lane_nz = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_ea      = r_a[16*(N-i)-2 -: 8];
            w_eb      = r_b[16*(N-i)-2 -: 8];
            w_pe_i    = {1'b0, w_ea} + {1'b0, w_eb};
            w_lane_nz = (w_ea != 8'h00) && (w_eb != 8'h00);
            w_maxpe   = (w_lane_nz && (w_pe_i > w_maxpe)) ? w_pe_i : w_maxpe;
            w_nz      = w_nz | w_lane_nz;
            w_special = w_special | (w_ea == 8'hFF) | (w_eb == 8'hFF);
        end
    end

    // Current lane's product, aligned to the maximum product exponent.
    assign w_ua      = bf16_unpack(r_a[16*(N-1-int'(r_cnt)) +: 16]);
    assign w_ub      = bf16_unpack(r_b[16*(N-1-int'(r_cnt)) +: 16]);
    assign w_pe      = {1'b0, w_ua.exp} + {1'b0, w_ub.exp};
    assign w_shift   = r_maxpe - w_pe;
    assign w_prod    = 16'(w_ua.mant) * 16'(w_ub.mant);
    assign w_prod_g  = PW'(w_prod) << GUARD;
    assign w_mag     = ((w_ua.exp == 8'h00) || (w_ub.exp == 8'h00) || (w_shift >= 9'(PW)))
                       ? '0 : (w_prod_g >> w_shift);
    assign w_mag_ext = ACC_W'(w_mag);
    assign w_term    = (w_ua.sign ^ w_ub.sign) ? (-w_mag_ext) : w_mag_ext;

    assign w_sign = r_acc[ACC_W-1];
    assign w_abs  = w_sign ? (-r_acc) : r_acc;

    bf16_lzd #(.W(ACC_W)) u_lzd (
        .i_data (w_abs),
        .o_idx  (w_p),
        .o_zero (w_zero)
    );

    // Normalise the accumulator and pack the BF16 result.
    always_comb begin
        w_e = 12'(r_maxpe) - 12'(BF16_BIAS) + 12'(w_p) - 12'(FRAC);
        if (w_p >= IW'(MANT_W)) begin
            w_mant = MANT_W'(w_abs >> (w_p - IW'(MANT_W)));
        end else begin
            w_mant = MANT_W'(w_abs << (IW'(MANT_W) - w_p));
        end
        if (r_special) begin
            w_result = BF16_QNAN;
        end else if (w_zero || !r_nz) begin
            w_result = 16'h0000;
        end else if (w_e <= 12'sd0) begin
            w_result = {w_sign, 15'h0000};
        end else if (w_e >= 12'sd255) begin
            w_result = {w_sign, 8'hFF, 7'h00};
        end else begin
            w_result = {w_sign, w_e[7:0], w_mant};
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_OUT);
        end
    end

    // Operand capture, exponent scan results, MAC and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_maxpe   <= 9'd0;
            r_nz      <= 1'b0;
            r_special <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dot_out <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_a   <= bf16_a;
                r_b   <= bf16_b;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_ACC) begin
                r_acc <= r_acc + w_term;
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ST_MAXEXP) begin
                r_maxpe   <= w_maxpe;
                r_nz      <= w_nz;
                r_special <= w_special;
            end
            if (r_state == ST_NORM) begin
                r_dot_out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_bf16_dot_cim_seq.sv
// Directed bench for bf16_dot_cim_seq with two lanes and hand-computed results.
module tb_bf16_dot_cim_seq;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [16*N-1:0] bf16_a = '0;
    logic [16*N-1:0] bf16_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     dot_out;

    int n_assert = 0;
    int n_fail   = 0;

    bf16_dot_cim_seq #(.N(N), .GUARD(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bf16_a    (bf16_a),
        .bf16_b    (bf16_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dot_out   (dot_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        bf16_a   = a;
        bf16_b   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(N + 2));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] exp);
        start_op(tag, a, b);
        wait_out(tag);
        check(tag, 32'(dot_out), 32'(exp));
        release_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dot_out", 32'(dot_out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sum 1*1 + 2*1 = 3.0
        run_op("t1_sum3", {16'h3F80, 16'h4000}, {16'h3F80, 16'h3F80}, 16'h4040);
        // Cancellation and all-zero
        run_op("t2_cancel", {16'h3F80, 16'hBF80}, {16'h3F80, 16'h3F80}, 16'h0000);
        run_op("t2_zero", {16'h0000, 16'h0000}, {16'h0000, 16'h0000}, 16'h0000);
        // Alignment truncation and negative result
        run_op("t3_align", {16'h4300, 16'h3F80}, {16'h3F80, 16'h3B80}, 16'h4300);
        run_op("t3_neg", {16'hC000, 16'h3F80}, {16'h3F80, 16'h3F80}, 16'hBF80);
        // Specials, overflow, underflow
        run_op("t4_nan", {16'h7F80, 16'h3F80}, {16'h3F80, 16'h4000}, 16'h7FC0);
        run_op("t4_ovf", {16'h7F00, 16'h7F00}, {16'h4000, 16'h4000}, 16'h7F80);
        run_op("t4_unf", {16'h0080, 16'h0080}, {16'h0080, 16'h0080}, 16'h0000);

        // Back-pressure with an in_valid pulse that must be ignored
        start_op("t5", {16'hC000, 16'h3F80}, {16'h3F80, 16'h3F80});
        wait_out("t5");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                bf16_a   = {16'h7F80, 16'h7F80};
                bf16_b   = {16'h3F80, 16'h3F80};
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("t5_hold_dot", 32'(dot_out), 32'hBF80);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_ready", 32'(in_ready), 32'd0);
        end
        release_out("t5");
        run_op("t5_next", {16'h4300, 16'h3F80}, {16'h3F80, 16'h3B80}, 16'h4300);

        // Reset in the middle of accumulation
        start_op("t6", {16'h3F80, 16'h4000}, {16'h3F80, 16'h3F80});
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_dot", 32'(dot_out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_rel_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("t6_no_partial", 32'(seen_valid), 32'd0);
        run_op("t6_after", {16'h3F80, 16'h4000}, {16'h3F80, 16'h3F80}, 16'h4040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
